// File: rtl/skel_pkg.sv
// Shared types and neighbourhood helpers for the Zhang-Suen skeleton engine.
package skel_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READY = 3'd2,
      SCAN  = 3'd3,
      APPLY = 3'd4
   } skel_state_t;

   // P2 = north, then clockwise to P9 = north-west.
   typedef struct packed {
      logic p2;
      logic p3;
      logic p4;
      logic p5;
      logic p6;
      logic p7;
      logic p8;
      logic p9;
   } nbhd_t;

   function automatic logic [3:0] countB(input nbhd_t n);
      return {3'd0, n.p2} + {3'd0, n.p3} + {3'd0, n.p4} + {3'd0, n.p5} +
             {3'd0, n.p6} + {3'd0, n.p7} + {3'd0, n.p8} + {3'd0, n.p9};
   endfunction

   // 0->1 transitions around the ring P2..P9 and back to P2.
   function automatic logic [3:0] countA(input nbhd_t n);
      return {3'd0, !n.p2 && n.p3} + {3'd0, !n.p3 && n.p4} +
             {3'd0, !n.p4 && n.p5} + {3'd0, !n.p5 && n.p6} +
             {3'd0, !n.p6 && n.p7} + {3'd0, !n.p7 && n.p8} +
             {3'd0, !n.p8 && n.p9} + {3'd0, !n.p9 && n.p2};
   endfunction

endpackage

// File: rtl/zs_cell_test.sv
// Combinational Zhang-Suen deletion test for one pixel and its 8-neighbourhood.
module zs_cell_test
   import skel_pkg::*;
(
   input  logic  p1,
   input  nbhd_t nbhd,
   input  logic  sub,
   output logic  doDelete
);

   logic [3:0] bCount;
   logic [3:0] aCount;
   logic       cond0;
   logic       cond1;

   always_comb begin
      bCount   = countB(nbhd);
      aCount   = countA(nbhd);
      cond0    = !(nbhd.p2 && nbhd.p4 && nbhd.p6) && !(nbhd.p4 && nbhd.p6 && nbhd.p8);
      cond1    = !(nbhd.p2 && nbhd.p4 && nbhd.p8) && !(nbhd.p2 && nbhd.p6 && nbhd.p8);
      doDelete = p1 && (bCount >= 4'd2) && (bCount <= 4'd6) && (aCount == 4'd1) &&
                 (sub ? cond1 : cond0);
   end

endmodule

// File: rtl/skeleton_engine.sv
// Loads and binarises an N x N image, thins it with two-subiteration Zhang-Suen
// passes, and exposes the skeleton through a registered read port.
module skeleton_engine
   import skel_pkg::*;
#(
   parameter int unsigned N          = 8,
   parameter int unsigned pixelWidth = 8,
   parameter int unsigned THRESH     = 128,
   parameter int unsigned MAX_PASSES = 16,
   parameter int unsigned bitSize    = $clog2(N * N),
   parameter int unsigned PC_W       = $clog2(MAX_PASSES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [pixelWidth-1:0] load_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  limit_hit,
   output logic [PC_W-1:0]       pass_count,
   input  logic [bitSize-1:0]    rd_addr,
   output logic [pixelWidth-1:0] rd_data
);

   localparam int unsigned NN = N * N;
   localparam int unsigned coordW = $clog2(N);
   localparam logic [coordW-1:0]     lastCoord = coordW'(N - 1);
   localparam logic [bitSize-1:0]    lastIdx   = bitSize'(NN - 1);
   localparam logic [bitSize-1:0]    rowStep   = bitSize'(N);
   localparam logic [bitSize-1:0]    oneIdx    = bitSize'(1);
   localparam logic [PC_W-1:0]       maxPc     = PC_W'(MAX_PASSES);
   localparam logic [PC_W-1:0]       onePc     = PC_W'(1);
   localparam logic [pixelWidth-1:0] thrVal    = pixelWidth'(THRESH);

   skel_state_t         stateQ, stateD;
   logic [NN-1:0]       imageQ, imageD;
   logic [NN-1:0]       markQ, markD;
   logic [bitSize-1:0]  wptrQ, wptrD;
   logic [bitSize-1:0]  idxQ, idxD;
   logic [coordW-1:0]   rowQ, rowD;
   logic [coordW-1:0]   colQ, colD;
   logic                subQ, subD;
   logic                changedQ, changedD;
   logic [PC_W-1:0]     passQ, passD;
   logic                limitQ, limitD;
   logic                doneQ, doneD;
   logic [pixelWidth-1:0] rdQ, rdD;

   logic  pixBit;
   logic  hasN, hasS, hasW, hasE;
   nbhd_t nb;
   logic  delBit;
   logic  anyChange;
   logic  rdBit;

   // Neighbours outside the image read as background.
   always_comb begin
      hasN  = (rowQ != '0);
      hasS  = (rowQ != lastCoord);
      hasW  = (colQ != '0);
      hasE  = (colQ != lastCoord);
      nb.p2 = hasN && imageQ[idxQ - rowStep];
      nb.p3 = hasN && hasE && imageQ[idxQ - rowStep + oneIdx];
      nb.p4 = hasE && imageQ[idxQ + oneIdx];
      nb.p5 = hasS && hasE && imageQ[idxQ + rowStep + oneIdx];
      nb.p6 = hasS && imageQ[idxQ + rowStep];
      nb.p7 = hasS && hasW && imageQ[idxQ + rowStep - oneIdx];
      nb.p8 = hasW && imageQ[idxQ - oneIdx];
      nb.p9 = hasN && hasW && imageQ[idxQ - rowStep - oneIdx];
   end

   zs_cell_test u_cell (
      .p1       (imageQ[idxQ]),
      .nbhd     (nb),
      .sub      (subQ),
      .doDelete (delBit)
   );

   always_comb begin
      pixBit    = (load_data >= thrVal);
      anyChange = changedQ || (markQ != '0);
      stateD    = stateQ;
      imageD    = imageQ;
      markD     = markQ;
      wptrD     = wptrQ;
      idxD      = idxQ;
      rowD      = rowQ;
      colD      = colQ;
      subD      = subQ;
      changedD  = changedQ;
      passD     = passQ;
      limitD    = limitQ;
      doneD     = 1'b0;

      unique case (stateQ)
         IDLE: begin
            if (load_valid) begin
               imageD[0] = pixBit;
               wptrD     = oneIdx;
               stateD    = LOAD;
            end
         end
         LOAD: begin
            if (load_valid) begin
               imageD[wptrQ] = pixBit;
               if (wptrQ == lastIdx) begin
                  wptrD  = '0;
                  stateD = READY;
               end else begin
                  wptrD = wptrQ + oneIdx;
               end
            end
         end
         READY: begin
            if (start) begin
               stateD   = SCAN;
               subD     = 1'b0;
               idxD     = '0;
               rowD     = '0;
               colD     = '0;
               passD    = '0;
               limitD   = 1'b0;
               changedD = 1'b0;
            end else if (load_valid) begin
               imageD[0] = pixBit;
               wptrD     = oneIdx;
               stateD    = LOAD;
            end
         end
         SCAN: begin
            markD[idxQ] = delBit;
            if (idxQ == lastIdx) begin
               idxD   = '0;
               rowD   = '0;
               colD   = '0;
               stateD = APPLY;
            end else begin
               idxD = idxQ + oneIdx;
               if (colQ == lastCoord) begin
                  colD = '0;
                  rowD = rowQ + coordW'(1);
               end else begin
                  colD = colQ + coordW'(1);
               end
            end
         end
         APPLY: begin
            imageD = imageQ & ~markQ;
            markD  = '0;
            if (!subQ) begin
               subD     = 1'b1;
               changedD = anyChange;
               stateD   = SCAN;
            end else begin
               passD = (passQ == maxPc) ? passQ : passQ + onePc;
               if (!anyChange) begin
                  doneD  = 1'b1;
                  stateD = READY;
               end else if (passQ + onePc == maxPc) begin
                  doneD  = 1'b1;
                  limitD = 1'b1;
                  stateD = READY;
               end else begin
                  subD     = 1'b0;
                  changedD = 1'b0;
                  stateD   = SCAN;
               end
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // Addresses beyond the image (only possible when N*N is not a power of two) read 0.
   if (NN < (2 ** bitSize)) begin : g_rdGuard
      assign rdBit = (rd_addr <= lastIdx) && imageQ[rd_addr];
   end else begin : g_rdDirect
      assign rdBit = imageQ[rd_addr];
   end

   assign rdD = rdBit ? '1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= IDLE;
         imageQ   <= '0;
         markQ    <= '0;
         wptrQ    <= '0;
         idxQ     <= '0;
         rowQ     <= '0;
         colQ     <= '0;
         subQ     <= 1'b0;
         changedQ <= 1'b0;
         passQ    <= '0;
         limitQ   <= 1'b0;
         doneQ    <= 1'b0;
         rdQ      <= '0;
      end else begin
         stateQ   <= stateD;
         imageQ   <= imageD;
         markQ    <= markD;
         wptrQ    <= wptrD;
         idxQ     <= idxD;
         rowQ     <= rowD;
         colQ     <= colD;
         subQ     <= subD;
         changedQ <= changedD;
         passQ    <= passD;
         limitQ   <= limitD;
         doneQ    <= doneD;
         rdQ      <= rdD;
      end
   end

   always_comb begin
      busy       = (stateQ == SCAN) || (stateQ == APPLY);
      load_ready = (stateQ == IDLE) || (stateQ == LOAD) || ((stateQ == READY) && !start);
   end

   assign done       = doneQ;
   assign limit_hit  = limitQ;
   assign pass_count = passQ;
   assign rd_data    = rdQ;

endmodule

// File: tb/tb_skeleton_engine.sv
// Randomised scoreboard bench: two engines (MAX_PASSES 16 and 1) share stimulus and
// are checked against a grid-level Zhang-Suen reference model.
module tb_skeleton_engine;

   localparam int N     = 8;
   localparam int NN    = N * N;
   localparam int MAXP0 = 16;
   localparam int MAXP1 = 1;
   localparam int PC0   = $clog2(MAXP0 + 1);
   localparam int PC1   = $clog2(MAXP1 + 1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load_valid = 1'b0;
   logic [7:0]     load_data = 8'd0;
   logic           start = 1'b0;
   logic [5:0]     rd_addr = 6'd0;

   logic           lr0, busy0, done0, lim0;
   logic [PC0-1:0] pc0;
   logic [7:0]     rd0;
   logic           lr1, busy1, done1, lim1;
   logic [PC1-1:0] pc1;
   logic [7:0]     rd1;

   skeleton_engine #(.N(N), .pixelWidth(8), .THRESH(128), .MAX_PASSES(MAXP0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr0),
      .load_data(load_data), .start(start), .busy(busy0), .done(done0),
      .limit_hit(lim0), .pass_count(pc0), .rd_addr(rd_addr), .rd_data(rd0)
   );

   skeleton_engine #(.N(N), .pixelWidth(8), .THRESH(128), .MAX_PASSES(MAXP1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr1),
      .load_data(load_data), .start(start), .busy(busy1), .done(done1),
      .limit_hit(lim1), .pass_count(pc1), .rd_addr(rd_addr), .rd_data(rd1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int startEdge;
      int passes;
      int lim;
   } exp_t;

   typedef struct {
      int e0;
      int e1;
      int addr;
   } rd_t;

   exp_t q0[$];
   exp_t q1[$];
   rd_t  rdq[$];

   byte unsigned pix[NN];
   bit [NN-1:0]  curImg;
   bit [NN-1:0]  res0;
   bit [NN-1:0]  res1;

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int cellBit(input bit [NN-1:0] im, input int r, input int c);
      if (r < 0 || r >= N || c < 0 || c >= N) return 0;
      return int'(im[r*N+c]);
   endfunction

   function automatic bit [NN-1:0] subPass(input bit [NN-1:0] im, input int sub);
      bit [NN-1:0] outImg;
      int p[10];
      int b, a, nxt;
      bit cond;
      outImg = im;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (im[r*N+c]) begin
               p[2] = cellBit(im, r-1, c);   p[3] = cellBit(im, r-1, c+1);
               p[4] = cellBit(im, r, c+1);   p[5] = cellBit(im, r+1, c+1);
               p[6] = cellBit(im, r+1, c);   p[7] = cellBit(im, r+1, c-1);
               p[8] = cellBit(im, r, c-1);   p[9] = cellBit(im, r-1, c-1);
               b = 0;
               a = 0;
               for (int k = 2; k <= 9; k++) begin
                  b += p[k];
                  nxt = (k == 9) ? p[2] : p[k+1];
                  if (p[k] == 0 && nxt == 1) a++;
               end
               if (sub == 0) cond = (p[2]*p[4]*p[6] == 0) && (p[4]*p[6]*p[8] == 0);
               else          cond = (p[2]*p[4]*p[8] == 0) && (p[2]*p[6]*p[8] == 0);
               if (b >= 2 && b <= 6 && a == 1 && cond) outImg[r*N+c] = 1'b0;
            end
         end
      end
      return outImg;
   endfunction

   task automatic thin(input bit [NN-1:0] src, input int maxP, output int passes,
                       output int lim, output bit [NN-1:0] res);
      bit [NN-1:0] im;
      bit [NN-1:0] nxt;
      im     = src;
      passes = 0;
      lim    = 0;
      for (int k = 0; k < maxP; k++) begin
         nxt = subPass(subPass(im, 0), 1);
         passes++;
         if (nxt == im) break;
         im = nxt;
         if (passes == maxP) lim = 1;
      end
      res = im;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      rd_t  r;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (busy0) chk("load_ready_busy0", int'(lr0), 0);
            if (busy1) chk("load_ready_busy1", int'(lr1), 0);
            if (done0) begin
               if (q0.size() == 0) chk("unexpected_done0", 1, 0);
               else begin
                  e = q0.pop_front();
                  chk("done_latency0", cyc - e.startEdge, e.passes * 2 * (NN + 1));
                  chk("pass_count0", int'(pc0), e.passes);
                  chk("limit_hit0", int'(lim0), e.lim);
                  chk("busy_at_done0", int'(busy0), 0);
               end
            end
            if (done1) begin
               if (q1.size() == 0) chk("unexpected_done1", 1, 0);
               else begin
                  e = q1.pop_front();
                  chk("done_latency1", cyc - e.startEdge, e.passes * 2 * (NN + 1));
                  chk("pass_count1", int'(pc1), e.passes);
                  chk("limit_hit1", int'(lim1), e.lim);
                  chk("busy_at_done1", int'(busy1), 0);
               end
            end
            if (rdq.size() != 0) begin
               r = rdq.pop_front();
               chk($sformatf("rd_data0[%0d]", r.addr), int'(rd0), r.e0 ? 255 : 0);
               chk($sformatf("rd_data1[%0d]", r.addr), int'(rd1), r.e1 ? 255 : 0);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clearPix();
      for (int a = 0; a < NN; a++) pix[a] = 8'd0;
   endtask

   task automatic loadImage();
      for (int a = 0; a < NN; a++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            load_valid = 1'b0;
         end
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = pix[a];
         #1;
         chk("load_ready_load0", int'(lr0), 1);
         chk("load_ready_load1", int'(lr1), 1);
         curImg[a] = (pix[a] >= 8'd128);
      end
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic runStart(input bit holdValid, input bit waitDone);
      int p0, p1, l0, l1;
      @(negedge clk);
      start      = 1'b1;
      load_valid = holdValid;
      load_data  = 8'hFF;
      #1;
      chk("load_ready_start0", int'(lr0), 0);
      chk("load_ready_start1", int'(lr1), 0);
      thin(curImg, MAXP0, p0, l0, res0);
      thin(curImg, MAXP1, p1, l1, res1);
      q0.push_back('{cyc + 1, p0, l0});
      q1.push_back('{cyc + 1, p1, l1});
      @(negedge clk);
      start      = 1'b0;
      load_valid = 1'b0;
      if (waitDone) begin
         for (int i = 0; i < (MAXP0 + 1) * 2 * (NN + 1) + 20 &&
                         (q0.size() != 0 || q1.size() != 0); i++)
            @(negedge clk);
         if (q0.size() != 0 || q1.size() != 0) begin
            chk("done_timeout", int'(q0.size() + q1.size()), 0);
            q0.delete();
            q1.delete();
         end
      end
   endtask

   task automatic readAll();
      for (int a = 0; a < NN; a++) begin
         @(negedge clk);
         rd_addr = 6'(a);
         rdq.push_back('{int'(res0[a]), int'(res1[a]), a});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic randomPix();
      for (int a = 0; a < NN; a++) begin
         case ($urandom_range(0, 3))
            0: pix[a] = 8'd127;
            1: pix[a] = 8'd128;
            2: pix[a] = 8'($urandom_range(0, 255));
            default: pix[a] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
         endcase
      end
   endtask

   task automatic setBlock();
      clearPix();
      for (int r = 2; r <= 4; r++)
         for (int c = 2; c <= 4; c++) pix[r*N+c] = 8'd200;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_load_ready0", int'(lr0), 1);
      chk("reset_busy0", int'(busy0), 0);
      chk("reset_done0", int'(done0), 0);
      chk("reset_limit0", int'(lim0), 0);
      chk("reset_pass0", int'(pc0), 0);
      chk("reset_rd0", int'(rd0), 0);
      chk("reset_load_ready1", int'(lr1), 1);
      chk("reset_pass1", int'(pc1), 0);
      rst_n = 1'b1;

      // Empty image: one pass, nothing deleted.
      clearPix();
      loadImage();
      runStart(1'b0, 1'b1);
      readAll();

      // Solid 3x3 block thins to its centre.
      setBlock();
      loadImage();
      runStart(1'b0, 1'b1);
      readAll();

      // Thin line plus isolated pixel survive; 127 stays background; start beats load_valid.
      clearPix();
      for (int c = 1; c <= 5; c++) pix[3*N+c] = 8'd128;
      pix[6*N+6] = 8'd128;
      pix[0]     = 8'd127;
      loadImage();
      runStart(1'b1, 1'b1);
      readAll();

      for (int t = 0; t < 6; t++) begin
         randomPix();
         loadImage();
         runStart(1'($urandom_range(0, 1)), 1'b1);
         readAll();
      end

      // Asynchronous reset in the middle of a scan.
      randomPix();
      loadImage();
      runStart(1'b0, 1'b0);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy0", int'(busy0), 0);
      chk("midreset_load_ready0", int'(lr0), 1);
      chk("midreset_pass0", int'(pc0), 0);
      chk("midreset_busy1", int'(busy1), 0);
      chk("midreset_load_ready1", int'(lr1), 1);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      res0 = '0;
      res1 = '0;
      readAll();

      setBlock();
      loadImage();
      runStart(1'b0, 1'b1);
      readAll();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
